ac_motor_gate_monitor: RTL and testbench

//  Receive side of the dead-time stage. Watches the six gate drives (s1..s3 high/low)
//  and checks every commutation against the programmed dead time and for shoot-through.

---
 rtl/ac_motor_gate_monitor_if.sv | 42 ++++
 rtl/ac_motor_gate_monitor.sv | 192 +++++++++++++++++++
 tb/tb_ac_motor_gate_monitor.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ac_motor_gate_monitor_if.sv
// Gate-drive monitor bus: gate inputs, delay setting, fault and measurement outputs.
// Min-dead-time statistics signals exist only with AC_MOTOR_GATE_MONITOR_STATS_EN.
interface ac_motor_gate_monitor_if #(
  parameter int DELAY_W = 8
);
  logic [DELAY_W-1:0] delay;
  logic               s1_high;
  logic               s1_low;
  logic               s2_high;
  logic               s2_low;
  logic               s3_high;
  logic               s3_low;
  logic               fault_clear;
  logic               enable;
  logic               fault;
  logic [2:0]         fault_phase;
  logic [1:0]         fault_type;
  logic               dead_valid;
  logic [1:0]         dead_phase;
  logic [DELAY_W-1:0] dead_time;
`ifdef AC_MOTOR_GATE_MONITOR_STATS_EN
  logic [DELAY_W-1:0] min_dead_1;
  logic [DELAY_W-1:0] min_dead_2;
  logic [DELAY_W-1:0] min_dead_3;
`endif

  modport master (
    output delay, s1_high, s1_low, s2_high, s2_low, s3_high, s3_low, fault_clear,
    input  enable, fault, fault_phase, fault_type, dead_valid, dead_phase, dead_time
`ifdef AC_MOTOR_GATE_MONITOR_STATS_EN
    , input min_dead_1, min_dead_2, min_dead_3
`endif
  );

  modport slave (
    input  delay, s1_high, s1_low, s2_high, s2_low, s3_high, s3_low, fault_clear,
    output enable, fault, fault_phase, fault_type, dead_valid, dead_phase, dead_time
`ifdef AC_MOTOR_GATE_MONITOR_STATS_EN
    , output min_dead_1, min_dead_2, min_dead_3
`endif
  );
endinterface

// File: rtl/ac_motor_gate_monitor.sv
// Dead-time / shoot-through monitor for three gate-drive phases with latched fault and enable.
// Optional per-phase minimum dead-time statistics: define AC_MOTOR_GATE_MONITOR_STATS_EN.
module ac_motor_gate_monitor #(
  parameter int DELAY_W = 8
) (
  input logic                  clk,
  input logic                  reset,
  ac_motor_gate_monitor_if.slave bus
);
  typedef enum logic [1:0] {ST_OFF = 2'd0, ST_HI = 2'd1, ST_LO = 2'd2, ST_BOTH = 2'd3} phase_state_e;
  typedef enum logic [1:0] {SIDE_NONE = 2'd0, SIDE_HI = 2'd1, SIDE_LO = 2'd2} side_e;

  localparam logic [DELAY_W-1:0] CNT_MAX  = {DELAY_W{1'b1}};
  localparam logic [DELAY_W-1:0] CNT_ZERO = {DELAY_W{1'b0}};
  localparam logic [DELAY_W-1:0] CNT_ONE  = {{(DELAY_W-1){1'b0}}, 1'b1};

  logic [2:0]         gate_hi_s, gate_lo_s;
  phase_state_e       state_q [3];
  phase_state_e       state_d [3];
  side_e              side_q [3];
  side_e              side_d [3];
  logic [DELAY_W-1:0] cnt_q [3];
  logic [DELAY_W-1:0] cnt_d [3];
  logic [2:0]         comm_s, shoot_s, short_s;
  logic               det_s, clear_ok_s, gates_idle_s;

  logic               enable_q, enable_d;
  logic               fault_q, fault_d;
  logic [2:0]         fault_phase_q, fault_phase_d;
  logic [1:0]         fault_type_q, fault_type_d;
  logic               dead_valid_q, dead_valid_d;
  logic [1:0]         dead_phase_q, dead_phase_d;
  logic [DELAY_W-1:0] dead_time_q, dead_time_d;

  assign gate_hi_s    = {bus.s3_high, bus.s2_high, bus.s1_high};
  assign gate_lo_s    = {bus.s3_low,  bus.s2_low,  bus.s1_low};
  assign gates_idle_s = (gate_hi_s == 3'b000) && (gate_lo_s == 3'b000);

  // Per-phase gate decode, dead-time counter and commutation detection
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      side_d[i]  = side_q[i];
      cnt_d[i]   = cnt_q[i];
      comm_s[i]  = 1'b0;
      shoot_s[i] = 1'b0;
      case ({gate_hi_s[i], gate_lo_s[i]})
        2'b00: begin
          state_d[i] = ST_OFF;
          cnt_d[i]   = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + CNT_ONE;
        end
        2'b10: begin
          state_d[i] = ST_HI;
          side_d[i]  = SIDE_HI;
          cnt_d[i]   = CNT_ZERO;
          comm_s[i]  = (state_q[i] != ST_HI) && (side_q[i] == SIDE_LO);
        end
        2'b01: begin
          state_d[i] = ST_LO;
          side_d[i]  = SIDE_LO;
          cnt_d[i]   = CNT_ZERO;
          comm_s[i]  = (state_q[i] != ST_LO) && (side_q[i] == SIDE_HI);
        end
        2'b11: begin
          state_d[i] = ST_BOTH;
          cnt_d[i]   = CNT_ZERO;
          shoot_s[i] = 1'b1;
        end
        default: begin
          state_d[i] = ST_OFF;
        end
      endcase
      // A zero delay setting turns the short-dead-time check off entirely
      short_s[i] = comm_s[i] && (bus.delay != CNT_ZERO) && (cnt_q[i] < bus.delay);
    end
  end

  assign det_s      = (shoot_s != 3'b000) || (short_s != 3'b000);
  assign clear_ok_s = fault_q && bus.fault_clear && !det_s;

  // Fault latch, enable arming and measurement report selection
  always_comb begin
    fault_d       = fault_q;
    fault_phase_d = fault_phase_q;
    fault_type_d  = fault_type_q;
    if (det_s && (!fault_q || bus.fault_clear)) begin
      fault_d       = 1'b1;
      fault_phase_d = shoot_s | short_s;
      fault_type_d  = (shoot_s != 3'b000) ? 2'b10 : 2'b01;
    end else if (clear_ok_s) begin
      fault_d       = 1'b0;
      fault_phase_d = 3'b000;
      fault_type_d  = 2'b00;
    end else begin
      fault_d       = fault_q;
    end

    if (fault_d) begin
      enable_d = 1'b0;
    end else if (enable_q || (gates_idle_s && !fault_q)) begin
      enable_d = 1'b1;
    end else begin
      enable_d = 1'b0;
    end

    dead_valid_d = 1'b1;
    dead_phase_d = dead_phase_q;
    dead_time_d  = dead_time_q;
    if (comm_s[0]) begin
      dead_phase_d = 2'd1;
      dead_time_d  = cnt_q[0];
    end else if (comm_s[1]) begin
      dead_phase_d = 2'd2;
      dead_time_d  = cnt_q[1];
    end else if (comm_s[2]) begin
      dead_phase_d = 2'd3;
      dead_time_d  = cnt_q[2];
    end else begin
      dead_valid_d = 1'b0;
    end
  end

  // Monitor state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= ST_OFF;
        side_q[i]  <= SIDE_NONE;
        cnt_q[i]   <= CNT_ZERO;
      end
      enable_q      <= 1'b0;
      fault_q       <= 1'b0;
      fault_phase_q <= 3'b000;
      fault_type_q  <= 2'b00;
      dead_valid_q  <= 1'b0;
      dead_phase_q  <= 2'd0;
      dead_time_q   <= CNT_ZERO;
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        side_q[i]  <= side_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      enable_q      <= enable_d;
      fault_q       <= fault_d;
      fault_phase_q <= fault_phase_d;
      fault_type_q  <= fault_type_d;
      dead_valid_q  <= dead_valid_d;
      dead_phase_q  <= dead_phase_d;
      dead_time_q   <= dead_time_d;
    end
  end

  assign bus.enable      = enable_q;
  assign bus.fault       = fault_q;
  assign bus.fault_phase = fault_phase_q;
  assign bus.fault_type  = fault_type_q;
  assign bus.dead_valid  = dead_valid_q;
  assign bus.dead_phase  = dead_phase_q;
  assign bus.dead_time   = dead_time_q;

`ifdef AC_MOTOR_GATE_MONITOR_STATS_EN
  logic [DELAY_W-1:0] min_dead_q [3];
  logic [DELAY_W-1:0] min_dead_d [3];
  logic [DELAY_W-1:0] min_base_s [3];

  // Running minimum per phase; an accepted clear restarts it before this cycle's sample
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      min_base_s[i] = clear_ok_s ? CNT_MAX : min_dead_q[i];
      if (comm_s[i] && (cnt_q[i] < min_base_s[i])) begin
        min_dead_d[i] = cnt_q[i];
      end else begin
        min_dead_d[i] = min_base_s[i];
      end
    end
  end

  // Minimum dead-time registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) min_dead_q[i] <= CNT_MAX;
    end else begin
      for (int i = 0; i < 3; i++) min_dead_q[i] <= min_dead_d[i];
    end
  end

  assign bus.min_dead_1 = min_dead_q[0];
  assign bus.min_dead_2 = min_dead_q[1];
  assign bus.min_dead_3 = min_dead_q[2];
`endif
endmodule

// File: tb/tb_ac_motor_gate_monitor.sv
// Directed self-checking bench for ac_motor_gate_monitor (stats section needs AC_MOTOR_GATE_MONITOR_STATS_EN).
module tb_ac_motor_gate_monitor;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  ac_motor_gate_monitor_if #(.DELAY_W(8)) bus ();

  ac_motor_gate_monitor #(.DELAY_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ph(input int p, input logic h, input logic l);
    case (p)
      1: begin bus.s1_high = h; bus.s1_low = l; end
      2: begin bus.s2_high = h; bus.s2_low = l; end
      3: begin bus.s3_high = h; bus.s3_low = l; end
      default: begin end
    endcase
  endtask

  task automatic clear_fault();
    set_ph(1, 1'b0, 1'b0); set_ph(2, 1'b0, 1'b0); set_ph(3, 1'b0, 1'b0);
    bus.fault_clear = 1'b1;
    tick();
    bus.fault_clear = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++; if (bus.enable !== 1'b0) begin errors++; $display("FAIL rst_enable got=%0d exp=0", bus.enable); end
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL rst_fault got=%0d exp=0", bus.fault); end
    checks++; if (bus.fault_phase !== 3'b000) begin errors++; $display("FAIL rst_fault_phase got=%b exp=000", bus.fault_phase); end
    checks++; if (bus.fault_type !== 2'b00) begin errors++; $display("FAIL rst_fault_type got=%b exp=00", bus.fault_type); end
    checks++; if (bus.dead_valid !== 1'b0) begin errors++; $display("FAIL rst_dead_valid got=%0d exp=0", bus.dead_valid); end
    checks++; if (bus.dead_phase !== 2'd0) begin errors++; $display("FAIL rst_dead_phase got=%0d exp=0", bus.dead_phase); end
    checks++; if (bus.dead_time !== 8'd0) begin errors++; $display("FAIL rst_dead_time got=%0d exp=0", bus.dead_time); end
    reset = 1'b0;
    tick();
    checks++; if (bus.enable !== 1'b1) begin errors++; $display("FAIL arm_enable got=%0d exp=1", bus.enable); end
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL arm_fault got=%0d exp=0", bus.fault); end
  endtask

  task automatic test_dead_time();
    set_ph(1, 1'b1, 1'b0); tick();
    checks++; if (bus.dead_valid !== 1'b0) begin errors++; $display("FAIL first_on_no_report got=%0d exp=0", bus.dead_valid); end
    set_ph(1, 1'b0, 1'b0); repeat (12) tick();
    set_ph(1, 1'b0, 1'b1); tick();
    checks++; if (bus.dead_valid !== 1'b1) begin errors++; $display("FAIL p1_dead_valid got=%0d exp=1", bus.dead_valid); end
    checks++; if (bus.dead_phase !== 2'd1) begin errors++; $display("FAIL p1_dead_phase got=%0d exp=1", bus.dead_phase); end
    checks++; if (bus.dead_time !== 8'd12) begin errors++; $display("FAIL p1_dead_time got=%0d exp=12", bus.dead_time); end
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL p1_fault got=%0d exp=0", bus.fault); end
    set_ph(1, 1'b0, 1'b0); tick();
    checks++; if (bus.dead_valid !== 1'b0) begin errors++; $display("FAIL p1_valid_pulse got=%0d exp=0", bus.dead_valid); end
    checks++; if (bus.dead_time !== 8'd12) begin errors++; $display("FAIL p1_dead_hold got=%0d exp=12", bus.dead_time); end
  endtask

  task automatic test_dead_short();
    set_ph(2, 1'b0, 1'b1); tick();
    set_ph(2, 1'b0, 1'b0); repeat (4) tick();
    set_ph(2, 1'b1, 1'b0); tick();
    checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL p2_fault got=%0d exp=1", bus.fault); end
    checks++; if (bus.fault_phase !== 3'b010) begin errors++; $display("FAIL p2_fault_phase got=%b exp=010", bus.fault_phase); end
    checks++; if (bus.fault_type !== 2'b01) begin errors++; $display("FAIL p2_fault_type got=%b exp=01", bus.fault_type); end
    checks++; if (bus.enable !== 1'b0) begin errors++; $display("FAIL p2_enable got=%0d exp=0", bus.enable); end
    checks++; if (bus.dead_time !== 8'd4) begin errors++; $display("FAIL p2_dead_time got=%0d exp=4", bus.dead_time); end
    set_ph(2, 1'b0, 1'b0); bus.fault_clear = 1'b1; tick(); bus.fault_clear = 1'b0;
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL clr_fault got=%0d exp=0", bus.fault); end
    checks++; if (bus.fault_phase !== 3'b000) begin errors++; $display("FAIL clr_fault_phase got=%b exp=000", bus.fault_phase); end
    checks++; if (bus.fault_type !== 2'b00) begin errors++; $display("FAIL clr_fault_type got=%b exp=00", bus.fault_type); end
    checks++; if (bus.enable !== 1'b0) begin errors++; $display("FAIL clr_enable_early got=%0d exp=0", bus.enable); end
    tick();
    checks++; if (bus.enable !== 1'b1) begin errors++; $display("FAIL clr_rearm got=%0d exp=1", bus.enable); end
    bus.fault_clear = 1'b1; tick(); bus.fault_clear = 1'b0;
    checks++; if (bus.fault !== 1'b0 || bus.enable !== 1'b1) begin errors++; $display("FAIL idle_clear got=%0d/%0d exp=0/1", bus.fault, bus.enable); end
  endtask

  task automatic test_simultaneous();
    repeat (20) tick();
    set_ph(1, 1'b1, 1'b0); tick();
    set_ph(1, 1'b0, 1'b0); repeat (3) tick();
    set_ph(1, 1'b0, 1'b1); set_ph(3, 1'b1, 1'b1); tick();
    checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL sim_fault got=%0d exp=1", bus.fault); end
    checks++; if (bus.fault_phase !== 3'b101) begin errors++; $display("FAIL sim_fault_phase got=%b exp=101", bus.fault_phase); end
    checks++; if (bus.fault_type !== 2'b10) begin errors++; $display("FAIL sim_fault_type got=%b exp=10", bus.fault_type); end
    checks++; if (bus.enable !== 1'b0) begin errors++; $display("FAIL sim_enable got=%0d exp=0", bus.enable); end
    checks++; if (bus.dead_phase !== 2'd1 || bus.dead_time !== 8'd3) begin errors++; $display("FAIL sim_report got=%0d/%0d exp=1/3", bus.dead_phase, bus.dead_time); end
    set_ph(1, 1'b0, 1'b0); set_ph(3, 1'b0, 1'b0); tick();
    set_ph(2, 1'b0, 1'b1); tick();
    set_ph(2, 1'b0, 1'b0); repeat (2) tick();
    set_ph(2, 1'b1, 1'b0); tick();
    checks++; if (bus.fault_phase !== 3'b101) begin errors++; $display("FAIL held_fault_phase got=%b exp=101", bus.fault_phase); end
    checks++; if (bus.fault_type !== 2'b10) begin errors++; $display("FAIL held_fault_type got=%b exp=10", bus.fault_type); end
    checks++; if (bus.dead_valid !== 1'b1 || bus.dead_phase !== 2'd2 || bus.dead_time !== 8'd2) begin
      errors++; $display("FAIL meas_in_fault got=%0d/%0d/%0d exp=1/2/2", bus.dead_valid, bus.dead_phase, bus.dead_time); end
    clear_fault();
    checks++; if (bus.fault !== 1'b0 || bus.enable !== 1'b1) begin errors++; $display("FAIL sim_recover got=%0d/%0d exp=0/1", bus.fault, bus.enable); end
  endtask

  task automatic test_delay_zero();
    bus.delay = 8'd0;
    set_ph(1, 1'b1, 1'b0); tick();
    set_ph(1, 1'b0, 1'b1); tick();
    checks++; if (bus.dead_valid !== 1'b1 || bus.dead_time !== 8'd0) begin errors++; $display("FAIL direct_dead got=%0d/%0d exp=1/0", bus.dead_valid, bus.dead_time); end
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL delay0_fault got=%0d exp=0", bus.fault); end
    set_ph(1, 1'b0, 1'b0); repeat (300) tick();
    set_ph(1, 1'b1, 1'b0); tick();
    checks++; if (bus.dead_time !== 8'd255) begin errors++; $display("FAIL sat_dead_time got=%0d exp=255", bus.dead_time); end
    checks++; if (bus.fault !== 1'b0 || bus.enable !== 1'b1) begin errors++; $display("FAIL sat_state got=%0d/%0d exp=0/1", bus.fault, bus.enable); end
  endtask

  task automatic test_boundary();
    bus.delay = 8'd10;
    set_ph(1, 1'b0, 1'b0); repeat (10) tick();
    set_ph(1, 1'b0, 1'b1); tick();
    checks++; if (bus.dead_time !== 8'd10 || bus.fault !== 1'b0) begin errors++; $display("FAIL equal_delay got=%0d/%0d exp=10/0", bus.dead_time, bus.fault); end
    set_ph(1, 1'b0, 1'b0); repeat (9) tick();
    set_ph(1, 1'b1, 1'b0); tick();
    checks++; if (bus.fault !== 1'b1 || bus.fault_phase !== 3'b001 || bus.fault_type !== 2'b01) begin
      errors++; $display("FAIL below_delay got=%0d/%b/%b exp=1/001/01", bus.fault, bus.fault_phase, bus.fault_type); end
    clear_fault();
    checks++; if (bus.enable !== 1'b1) begin errors++; $display("FAIL bnd_recover got=%0d exp=1", bus.enable); end
  endtask

`ifdef AC_MOTOR_GATE_MONITOR_STATS_EN
  task automatic test_stats();
    bus.delay = 8'd5;
    checks++; if (bus.min_dead_1 !== 8'd255) begin errors++; $display("FAIL min1_after_clear got=%0d exp=255", bus.min_dead_1); end
    set_ph(1, 1'b1, 1'b0); tick();
    set_ph(1, 1'b0, 1'b0); repeat (20) tick();
    set_ph(1, 1'b0, 1'b1); tick();
    set_ph(1, 1'b0, 1'b0); repeat (7) tick();
    set_ph(1, 1'b1, 1'b0); tick();
    set_ph(1, 1'b0, 1'b0); repeat (15) tick();
    set_ph(1, 1'b0, 1'b1); tick();
    set_ph(1, 1'b0, 1'b0);
    checks++; if (bus.min_dead_1 !== 8'd7) begin errors++; $display("FAIL min_dead_1 got=%0d exp=7", bus.min_dead_1); end
    checks++; if (bus.min_dead_2 !== 8'd255) begin errors++; $display("FAIL min_dead_2 got=%0d exp=255", bus.min_dead_2); end
    checks++; if (bus.min_dead_3 !== 8'd255) begin errors++; $display("FAIL min_dead_3 got=%0d exp=255", bus.min_dead_3); end
    checks++; if (bus.dead_time !== 8'd15 || bus.fault !== 1'b0) begin errors++; $display("FAIL stats_last got=%0d/%0d exp=15/0", bus.dead_time, bus.fault); end
  endtask
`endif

  task automatic test_reset_mid();
    bus.delay = 8'd5;
    set_ph(2, 1'b0, 1'b1); tick();
    set_ph(2, 1'b0, 1'b0); tick();
    set_ph(2, 1'b1, 1'b0); tick();
    checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL pre_reset_fault got=%0d exp=1", bus.fault); end
    set_ph(1, 1'b1, 1'b0);
    reset = 1'b1; tick();
    checks++; if (bus.fault !== 1'b0 || bus.fault_phase !== 3'b000 || bus.fault_type !== 2'b00) begin
      errors++; $display("FAIL mid_rst_fault got=%0d/%b/%b exp=0/000/00", bus.fault, bus.fault_phase, bus.fault_type); end
    checks++; if (bus.dead_valid !== 1'b0 || bus.dead_phase !== 2'd0 || bus.dead_time !== 8'd0 || bus.enable !== 1'b0) begin
      errors++; $display("FAIL mid_rst_outputs got=%0d/%0d/%0d/%0d exp=0/0/0/0", bus.dead_valid, bus.dead_phase, bus.dead_time, bus.enable); end
`ifdef AC_MOTOR_GATE_MONITOR_STATS_EN
    checks++; if (bus.min_dead_1 !== 8'd255 || bus.min_dead_2 !== 8'd255 || bus.min_dead_3 !== 8'd255) begin
      errors++; $display("FAIL mid_rst_min got=%0d/%0d/%0d exp=255", bus.min_dead_1, bus.min_dead_2, bus.min_dead_3); end
`endif
    set_ph(1, 1'b0, 1'b0); set_ph(2, 1'b0, 1'b0);
    reset = 1'b0; tick();
    checks++; if (bus.enable !== 1'b1) begin errors++; $display("FAIL post_rst_enable got=%0d exp=1", bus.enable); end
    set_ph(2, 1'b0, 1'b1); tick();
    checks++; if (bus.dead_valid !== 1'b0 || bus.fault !== 1'b0) begin errors++; $display("FAIL post_rst_side got=%0d/%0d exp=0/0", bus.dead_valid, bus.fault); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus.delay = 8'd10;
    bus.fault_clear = 1'b0;
    set_ph(1, 1'b0, 1'b0); set_ph(2, 1'b0, 1'b0); set_ph(3, 1'b0, 1'b0);
    test_reset();
    test_dead_time();
    test_dead_short();
    test_simultaneous();
    test_delay_zero();
    test_boundary();
`ifdef AC_MOTOR_GATE_MONITOR_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
